store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Register-to-memory store path. It is the opposite direction of the writeback select path, which carries data from ALU or memory into the register file.
- Takes a 64-bit register operand, a byte address and a store size (sb/sh/sw/sd).
- Performs an aligned read-modify-write on the 64-bit doubleword memory for sub-doubleword stores. Aligned sd goes straight to a single write.
- Sits between the control unit (START/DONE handshake) and the data memory port.

Parameters:
MEM_LAT, 1, memory read latency in cycles: MEM_DATA_IN is valid MEM_LAT cycles after MEM_ADDR is presented; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
START  in  1  request strobe; sampled only in IDLE
STORE_SIZE  in  2  00=sb, 01=sh, 10=sw, 11=sd; sampled with START
ADDR  in  64  byte address; sampled with START
REG_DATA  in  64  register operand (rs2); sampled with START
MEM_DATA_IN  in  64  memory read data
MEM_ADDR  out  64  doubleword-aligned address {addr[63:3],3'b000}
MEM_DATA_OUT  out  64  merged write data
MEM_WR  out  1  memory write enable
BUSY  out  1  high whenever state != IDLE
DONE  out  1  one-cycle completion pulse
MISALIGNED  out  1  one-cycle pulse, coincident with DONE, on misaligned request

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE.
  - MEM_ADDR=0, MEM_DATA_OUT=0.
  - MEM_WR=0, BUSY=0, DONE=0, MISALIGNED=0.
  - Latched size/offset/data cleared.
- All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- States: IDLE, RD_WAIT, CAPTURE, WRITE, FIN.
- IDLE:
  - If START=1, latch ADDR, STORE_SIZE and REG_DATA.
  - Load MEM_ADDR with the aligned address.
  - Compute misalignment:
    - sh: ADDR[0]!=0
    - sw: ADDR[1:0]!=0
    - sd: ADDR[2:0]!=0
    - sb: never misaligned
  - Transitions:
    - misaligned -> FIN, with the error flag set.
    - aligned sd -> WRITE, with MEM_DATA_OUT=REG_DATA.
    - otherwise -> RD_WAIT, with the wait counter=MEM_LAT.
  - START=0 -> stay in IDLE.
- RD_WAIT:
  - MEM_ADDR is held.
  - Counter decrements each cycle.
  - Leave for CAPTURE after exactly MEM_LAT cycles in RD_WAIT.
- CAPTURE:
  - At the clock edge ending this cycle, MEM_DATA_OUT <= merge(MEM_DATA_IN).
  - -> WRITE.
- Merge rules:
  - Little-endian byte lanes, offset o=addr[2:0].
  - sb: byte o <= REG_DATA[7:0].
  - sh: bytes o..o+1 <= REG_DATA[15:0].
  - sw: bytes o..o+3 <= REG_DATA[31:0].
  - All other bytes are kept from MEM_DATA_IN.
- WRITE:
  - MEM_WR=1 for exactly this one cycle.
  - MEM_ADDR and MEM_DATA_OUT are stable for the whole cycle.
  - -> FIN.
- FIN:
  - DONE=1 for one cycle.
  - MISALIGNED=1 in the same cycle if the error flag is set.
  - Clear the error flag; -> IDLE.
- Latency, counted from the START-sampling edge to the edge that asserts DONE:
  - misaligned: 1 cycle.
  - aligned sd: 2 cycles.
  - sb/sh/sw: MEM_LAT+3 cycles.
- START while BUSY is ignored, including in FIN. The next request is accepted at the earliest in the cycle after DONE.
- The misaligned path never asserts MEM_WR and never modifies memory.
- Inputs may change freely after START is sampled. The unit uses only latched values.
- Reset mid-operation:
  - Immediate return to IDLE; MEM_WR drops asynchronously.
  - No write is issued after reset deasserts.
  - No DONE pulse for the aborted request.
- Address wrap is not special-cased. The aligned address is a pure mask of ADDR, so ADDR=64'hFFFF_FFFF_FFFF_FFFF yields MEM_ADDR=64'hFFFF_FFFF_FFFF_FFF8.

Test Plan:
- Aligned sd: ADDR=0x40, REG_DATA=0x1122334455667788 -> MEM_WR one cycle at edge+1 with MEM_ADDR=0x40 and data 0x1122334455667788. DONE 2 cycles after START. MEM_DATA_IN is never used.
- sb at ADDR=0x43, mem=0xFFFFFFFFFFFFFFFF, REG_DATA=0xAB, MEM_LAT=1 -> MEM_ADDR=0x40, write data 0xFFFFFFFFABFFFFFF. DONE 4 cycles after START.
- sw at ADDR=0x104, mem=0x0, REG_DATA=0xDEADBEEFCAFEBABE -> write 0xCAFEBABE00000000 to 0x100. Also run with MEM_LAT=3 and check DONE 6 cycles after START.
- Misaligned sh at ADDR=0x21 -> DONE and MISALIGNED together 1 cycle after START. MEM_WR stays 0 throughout.
- Assert START continuously for 20 cycles with a back-to-back sb sequence -> each request completes. A new request is accepted only in IDLE, exactly one MEM_WR per request.
- rst_n pulsed low during RD_WAIT of an sh -> BUSY=0 and MEM_WR=0 immediately. No MEM_WR and no DONE afterward. The next aligned sd completes normally.

Source files
------------

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - register-to-memory store path with aligned doubleword read-modify-write
module store_rmw_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        START,
    input  logic [1:0]  STORE_SIZE,
    input  logic [63:0] ADDR,
    input  logic [63:0] REG_DATA,
    input  logic [63:0] MEM_DATA_IN,
    output logic [63:0] MEM_ADDR,
    output logic [63:0] MEM_DATA_OUT,
    output logic        MEM_WR,
    output logic        BUSY,
    output logic        DONE,
    output logic        MISALIGNED
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_CAPTURE,
        S_WRITE,
        S_FIN
    } state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] data_q;
    logic        err_q;
    logic [3:0]  cnt;

    logic        mis;
    logic [7:0]  mask;
    logic [7:0]  be;
    logic [63:0] shifted;
    logic [63:0] merged;

    // Alignment check on the live request inputs, only consumed in IDLE when START is high
    always_comb begin
        mis = 1'b0;
        case (STORE_SIZE)
            2'b01:   mis = ADDR[0];
            2'b10:   mis = |ADDR[1:0];
            2'b11:   mis = |ADDR[2:0];
            default: mis = 1'b0;
        endcase
    end

    // Byte-lane merge of the latched operand into the doubleword read back from memory
    always_comb begin
        mask    = 8'h0F;
        be      = 8'h00;
        shifted = data_q << {off_q, 3'b000};
        merged  = MEM_DATA_IN;
        case (size_q)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            default: mask = 8'h0F;
        endcase
        be = mask << off_q;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = shifted[i*8 +: 8];
            end
        end
    end

    assign BUSY = (state != S_IDLE);

    // Store sequencer: latch request, optional read wait, merge, single write, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            size_q       <= 2'b00;
            off_q        <= 3'b000;
            data_q       <= 64'h0;
            err_q        <= 1'b0;
            cnt          <= 4'h0;
            MEM_ADDR     <= 64'h0;
            MEM_DATA_OUT <= 64'h0;
            MEM_WR       <= 1'b0;
            DONE         <= 1'b0;
            MISALIGNED   <= 1'b0;
        end else begin
            MEM_WR     <= 1'b0;
            DONE       <= 1'b0;
            MISALIGNED <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        size_q   <= STORE_SIZE;
                        off_q    <= ADDR[2:0];
                        data_q   <= REG_DATA;
                        MEM_ADDR <= {ADDR[63:3], 3'b000};
                        if (mis) begin
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else if (STORE_SIZE == 2'b11) begin
                            MEM_DATA_OUT <= REG_DATA;
                            MEM_WR       <= 1'b1;
                            state        <= S_WRITE;
                        end else begin
                            cnt   <= LAT;
                            state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    MEM_DATA_OUT <= merged;
                    MEM_WR       <= 1'b1;
                    state        <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_FIN;
                end
                S_FIN: begin
                    DONE       <= 1'b1;
                    MISALIGNED <= err_q;
                    err_q      <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - randomized self-checking bench for store_rmw_unit against a store-level model
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic [1:0]  size;
    logic [63:0] addr, rdata;
    logic [63:0] mdin1, mdin3, maddr1, maddr3, mdout1, mdout3;
    logic        wr1, wr3, busy1, busy3, done1, done3, mis1, mis3;
    logic        sel;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { int c; logic [63:0] a; logic [63:0] d; } wev_t;
    typedef struct { int c; logic m; } dev_t;
    typedef struct {
        bit has_w; int wcyc; logic [63:0] waddr; logic [63:0] wdata;
        int dcyc; logic mis;
    } exp_t;

    wev_t wlog[$];
    dev_t dlog[$];
    exp_t expq[$];

    logic [63:0] phys [logic [60:0]];
    logic [63:0] refm [logic [60:0]];

    logic [63:0] pipe1;
    logic [63:0] pipe3 [3];

    always #5 clk = ~clk;

    store_rmw_unit #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .START(start1), .STORE_SIZE(size), .ADDR(addr),
        .REG_DATA(rdata), .MEM_DATA_IN(mdin1), .MEM_ADDR(maddr1), .MEM_DATA_OUT(mdout1),
        .MEM_WR(wr1), .BUSY(busy1), .DONE(done1), .MISALIGNED(mis1)
    );

    store_rmw_unit #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .START(start3), .STORE_SIZE(size), .ADDR(addr),
        .REG_DATA(rdata), .MEM_DATA_IN(mdin3), .MEM_ADDR(maddr3), .MEM_DATA_OUT(mdout3),
        .MEM_WR(wr3), .BUSY(busy3), .DONE(done3), .MISALIGNED(mis3)
    );

    function automatic logic [63:0] base_val(input logic [60:0] idx);
        return {idx[28:0], 3'b101, idx[31:0]} ^ 64'hA5C3_5A3C_0F1E_F0E1;
    endfunction

    function automatic logic [63:0] phys_rd(input logic [63:0] a);
        return phys.exists(a[63:3]) ? phys[a[63:3]] : base_val(a[63:3]);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return refm.exists(a[63:3]) ? refm[a[63:3]] : base_val(a[63:3]);
    endfunction

    // memory read data appears MEM_LAT cycles after the address is presented
    always @(posedge clk) begin
        pipe1    <= phys_rd(maddr1);
        pipe3[0] <= phys_rd(maddr3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        cyc      <= cyc + 1;
    end
    assign mdin1 = pipe1;
    assign mdin3 = pipe3[2];

    // observe the selected unit away from the active edge; writes land in the memory here
    always @(negedge clk) begin
        logic w, dn, ms;
        logic [63:0] a, d;
        w  = sel ? wr3 : wr1;
        dn = sel ? done3 : done1;
        ms = sel ? mis3 : mis1;
        a  = sel ? maddr3 : maddr1;
        d  = sel ? mdout3 : mdout1;
        if (w) begin
            wlog.push_back('{cyc, a, d});
            phys[a[63:3]] = d;
        end
        if (dn) dlog.push_back('{cyc, ms});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_mem(input logic [63:0] a, input logic [63:0] v);
        phys[a[63:3]] = v;
        refm[a[63:3]] = v;
    endtask

    // store-level model: bytes [o, o+n) of the doubleword take the low n bytes of the operand
    task automatic predict(input int e, input logic [1:0] sz, input logic [63:0] a,
                           input logic [63:0] d, input int lat);
        exp_t x;
        int n, o;
        logic [63:0] v;
        n = 1 << sz;
        o = int'(a % 8);
        x.has_w = 1'b0; x.wcyc = 0; x.waddr = a & ~64'd7; x.wdata = 0;
        x.mis = ((a % n) != 0);
        if (x.mis) begin
            x.dcyc = e + 1;
        end else begin
            if (n == 8) begin
                v = d;
                x.wcyc = e;
                x.dcyc = e + 2;
            end else begin
                v = ref_rd(a);
                for (int b = 0; b < n; b++) v[(o+b)*8 +: 8] = d[b*8 +: 8];
                x.wcyc = e + lat + 1;
                x.dcyc = e + lat + 3;
            end
            x.has_w = 1'b1;
            x.wdata = v;
            refm[a[63:3]] = v;
        end
        expq.push_back(x);
    endtask

    task automatic check_logs(input string tag);
        exp_t e;
        dev_t dv;
        wev_t wv;
        int nw = 0;
        foreach (expq[i]) if (expq[i].has_w) nw++;
        check({tag, ".nwr"}, 64'(wlog.size()), 64'(nw));
        check({tag, ".ndone"}, 64'(dlog.size()), 64'(expq.size()));
        while (expq.size() > 0) begin
            e = expq.pop_front();
            if (dlog.size() > 0) begin
                dv = dlog.pop_front();
                check({tag, ".done_cyc"}, 64'(dv.c), 64'(e.dcyc));
                check({tag, ".mis"}, 64'(dv.m), 64'(e.mis));
            end
            if (e.has_w && wlog.size() > 0) begin
                wv = wlog.pop_front();
                check({tag, ".wr_cyc"}, 64'(wv.c), 64'(e.wcyc));
                check({tag, ".wr_addr"}, wv.a, e.waddr);
                check({tag, ".wr_data"}, wv.d, e.wdata);
            end
        end
        wlog.delete();
        dlog.delete();
    endtask

    task automatic scramble();
        size  = 2'($urandom);
        addr  = {$urandom, $urandom};
        rdata = {$urandom, $urandom};
    endtask

    task automatic issue(input logic s, input logic [1:0] sz, input logic [63:0] a,
                         input logic [63:0] d, input string tag);
        int lat;
        lat = s ? 3 : 1;
        @(negedge clk);
        sel = s; size = sz; addr = a; rdata = d;
        if (s) start3 = 1'b1; else start1 = 1'b1;
        predict(cyc + 1, sz, a, d, lat);
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        scramble();
        repeat (lat + 5) @(negedge clk);
        check_logs(tag);
    endtask

    initial begin
        int e, next_ok;
        logic [1:0] sz;
        logic [63:0] a;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
        size = 2'b00; addr = 64'h0; rdata = 64'h0;
        repeat (3) @(negedge clk);
        check("rst.maddr", maddr1, 64'h0);
        check("rst.mdout", mdout1, 64'h0);
        check("rst.ctl1", {60'h0, wr1, busy1, done1, mis1}, 64'h0);
        check("rst.ctl3", {60'h0, wr3, busy3, done3, mis3}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 2'b11, 64'h40, 64'h1122334455667788, "sd_aligned");
        set_mem(64'h40, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b0, 2'b00, 64'h43, 64'h0000_0000_0000_00AB, "sb_0x43");
        check("sb_0x43.mem", phys_rd(64'h40), 64'hFFFF_FFFF_ABFF_FFFF);
        set_mem(64'h100, 64'h0);
        issue(1'b0, 2'b10, 64'h104, 64'hDEADBEEFCAFEBABE, "sw_lat1");
        set_mem(64'h100, 64'h0);
        issue(1'b1, 2'b10, 64'h104, 64'hDEADBEEFCAFEBABE, "sw_lat3");
        check("sw_lat3.mem", phys_rd(64'h100), 64'hCAFEBABE_0000_0000);
        issue(1'b0, 2'b01, 64'h21, 64'h1234, "sh_misal");
        issue(1'b1, 2'b11, 64'h44, 64'h5555, "sd_misal");
        issue(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77, "sb_wrap");
        issue(1'b0, 2'b01, 64'h206, 64'hBEEF, "sh_top");

        // START held high for 20 cycles with a fresh sb request every cycle
        sel = 1'b0;
        next_ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            sz = 2'b00;
            a  = 64'h300 + 64'($urandom_range(0, 23));
            size = sz; addr = a; rdata = {$urandom, $urandom};
            start1 = 1'b1;
            e = cyc + 1;
            if (e >= next_ok) begin
                predict(e, sz, a, rdata, 1);
                next_ok = e + 5;
            end
        end
        @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        check_logs("b2b");

        // reset during the read wait of a halfword store aborts it silently
        @(negedge clk);
        sel = 1'b1; size = 2'b01; addr = 64'h80; rdata = 64'h9999; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("rstmid.busy_before", 64'(busy3), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.busy", 64'(busy3), 64'd0);
        check("rstmid.wr", 64'(wr3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_logs("rstmid");
        issue(1'b1, 2'b11, 64'h88, 64'hCAFE_F00D_1234_5678, "after_rst");

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63)))
                                            : (64'h1000 + 64'($urandom_range(0, 63)));
            issue(1'($urandom), 2'($urandom), a, {$urandom, $urandom}, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
